dual_regfile: RTL and testbench



---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_read_port.sv | 37 +++
 rtl/dual_regfile.sv | 75 +++++++
 tb/tb_dual_regfile.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the dual-issue architectural register file.
// The write-request bundle is what each writeback lane presents per cycle.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO   = 5'd0;
    localparam reg_addr_t REG_STATUS = 5'd30;
    localparam reg_addr_t REG_LINK   = 5'd31;

    typedef struct packed {
        logic              we;
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register, same-cycle write bypass
// (bot lane is younger, so it is checked last and wins), then storage.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = 32
) (
    input  logic                        reset,
    input  reg_addr_t                   read_addr,
    input  wr_req_t                     wr_top,
    input  wr_req_t                     wr_bot,
    input  logic [NREGS-1:0][WIDTH-1:0] storage,
    output logic [WIDTH-1:0]            read_data
);

    logic top_hit;
    logic bot_hit;

    assign top_hit = !reset && wr_top.we && (wr_top.addr == read_addr);
    assign bot_hit = !reset && wr_bot.we && (wr_bot.addr == read_addr);

    // Later assignments override earlier ones, giving zero > bot > top > storage.
    always_comb begin
        read_data = storage[read_addr];
        if (top_hit) begin
            read_data = wr_top.data;
        end
        if (bot_hit) begin
            read_data = wr_bot.data;
        end
        if (read_addr == REG_ZERO) begin
            read_data = '0;
        end
    end

endmodule

// File: rtl/dual_regfile.sv
// Two-write, four-read architectural register file with write-through bypass.
// Owns the r1..r31 flops and resolves same-address write conflicts in favour of bot.
module dual_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_top,
    input  logic [4:0]       writeReg_top,
    input  logic [WIDTH-1:0] data_top,
    input  logic             we_bot,
    input  logic [4:0]       writeReg_bot,
    input  logic [WIDTH-1:0] data_bot,
    input  logic [4:0]       readRegA_top,
    input  logic [4:0]       readRegB_top,
    input  logic [4:0]       readRegA_bot,
    input  logic [4:0]       readRegB_bot,
    output logic [WIDTH-1:0] dataA_top,
    output logic [WIDTH-1:0] dataB_top,
    output logic [WIDTH-1:0] dataA_bot,
    output logic [WIDTH-1:0] dataB_bot
);

    wr_req_t                     wr_top;
    wr_req_t                     wr_bot;
    logic [WIDTH-1:0]            reg_q [1:NREGS-1];
    logic [NREGS-1:0][WIDTH-1:0] storage;

    assign wr_top = '{we: we_top, addr: writeReg_top, data: data_top};
    assign wr_bot = '{we: we_bot, addr: writeReg_bot, data: data_bot};

    // Reset beats any write; bot beats top on the same address; r0 has no flop.
    always_ff @(posedge clock) begin
        for (int i = 1; i < NREGS; i++) begin
            if (reset) begin
                reg_q[i] <= '0;
            end else if (we_bot && writeReg_bot == REG_ADDR_W'(i)) begin
                reg_q[i] <= data_bot;
            end else if (we_top && writeReg_top == REG_ADDR_W'(i)) begin
                reg_q[i] <= data_top;
            end
        end
    end

    always_comb begin
        storage    = '0;
        for (int i = 1; i < NREGS; i++) begin
            storage[i] = reg_q[i];
        end
    end

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_a_top (
        .reset(reset), .read_addr(readRegA_top), .wr_top(wr_top), .wr_bot(wr_bot),
        .storage(storage), .read_data(dataA_top)
    );

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_b_top (
        .reset(reset), .read_addr(readRegB_top), .wr_top(wr_top), .wr_bot(wr_bot),
        .storage(storage), .read_data(dataB_top)
    );

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_a_bot (
        .reset(reset), .read_addr(readRegA_bot), .wr_top(wr_top), .wr_bot(wr_bot),
        .storage(storage), .read_data(dataA_bot)
    );

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_b_bot (
        .reset(reset), .read_addr(readRegB_bot), .wr_top(wr_top), .wr_bot(wr_bot),
        .storage(storage), .read_data(dataB_bot)
    );

endmodule

// File: tb/tb_dual_regfile.sv
// Self-checking bench for dual_regfile: directed scenarios followed by random
// traffic compared against an array-based model of the register file.
module tb_dual_regfile;

    logic        clock;
    logic        reset;
    logic        we_top;
    logic [4:0]  writeReg_top;
    logic [31:0] data_top;
    logic        we_bot;
    logic [4:0]  writeReg_bot;
    logic [31:0] data_bot;
    logic [4:0]  readRegA_top;
    logic [4:0]  readRegB_top;
    logic [4:0]  readRegA_bot;
    logic [4:0]  readRegB_bot;
    logic [31:0] dataA_top;
    logic [31:0] dataB_top;
    logic [31:0] dataA_bot;
    logic [31:0] dataB_bot;

    logic [31:0] model_regs [32];
    int          check_count = 0;
    int          pass_count  = 0;

    dual_regfile #(.WIDTH(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset),
        .we_top(we_top), .writeReg_top(writeReg_top), .data_top(data_top),
        .we_bot(we_bot), .writeReg_bot(writeReg_bot), .data_bot(data_bot),
        .readRegA_top(readRegA_top), .readRegB_top(readRegB_top),
        .readRegA_bot(readRegA_bot), .readRegB_bot(readRegB_bot),
        .dataA_top(dataA_top), .dataB_top(dataB_top),
        .dataA_bot(dataA_bot), .dataB_bot(dataB_bot)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // What a reader of address a should see this cycle, from the architectural rules.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!reset && we_bot && writeReg_bot == a) return data_bot;
        if (!reset && we_top && writeReg_top == a) return data_top;
        return model_regs[a];
    endfunction

    task automatic apply_stimulus(input logic rst,
                                  input logic wt, input logic [4:0] at, input logic [31:0] dt,
                                  input logic wb, input logic [4:0] ab, input logic [31:0] db,
                                  input logic [4:0] r0, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic [4:0] r3);
        reset        = rst;
        we_top       = wt;
        writeReg_top = at;
        data_top     = dt;
        we_bot       = wb;
        writeReg_bot = ab;
        data_bot     = db;
        readRegA_top = r0;
        readRegB_top = r1;
        readRegA_bot = r2;
        readRegB_bot = r3;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic check_all_ports(input string tag);
        check_output({tag, "_A_top"}, dataA_top, model_read(readRegA_top));
        check_output({tag, "_B_top"}, dataB_top, model_read(readRegB_top));
        check_output({tag, "_A_bot"}, dataA_bot, model_read(readRegA_bot));
        check_output({tag, "_B_bot"}, dataB_bot, model_read(readRegB_bot));
    endtask

    // Clock edge: the model takes the same write/reset decision the edge should.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        end else begin
            if (we_top && writeReg_top != 5'd0) model_regs[writeReg_top] = data_top;
            if (we_bot && writeReg_bot != 5'd0) model_regs[writeReg_bot] = data_bot;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'hDEAD_BEEF;
        apply_stimulus(1, 1, 5'd4, 32'h9999, 1, 5'd6, 32'h7777, 0, 0, 0, 0);
        tick();
        tick();

        // Every address on every port reads zero after reset.
        for (int a = 0; a < 8; a++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'(4*a), 5'(4*a+1), 5'(4*a+2), 5'(4*a+3));
            check_output("reset_A_top", dataA_top, 32'd0);
            check_output("reset_B_top", dataB_top, 32'd0);
            check_output("reset_A_bot", dataA_bot, 32'd0);
            check_output("reset_B_bot", dataB_bot, 32'd0);
            tick();
        end

        apply_stimulus(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
        check_output("stored_r5", dataA_bot, 32'h0000_1234);

        apply_stimulus(0, 1, 5'd7, 32'hAAAA_0000, 0, 0, 0, 0, 5'd7, 0, 0);
        check_output("bypass_r7", dataB_top, 32'hAAAA_0000);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
        check_output("stored_r7", dataB_top, 32'hAAAA_0000);

        apply_stimulus(0, 1, 5'd9, 32'h11, 1, 5'd9, 32'h22, 5'd9, 0, 5'd9, 0);
        check_output("conflict_bypass_top", dataA_top, 32'h22);
        check_output("conflict_bypass_bot", dataA_bot, 32'h22);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0, 0);
        check_output("conflict_stored", dataA_top, 32'h22);

        apply_stimulus(0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 5'd0);
        check_output("r0_bypass", dataB_bot, 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        check_output("r0_stored", dataB_bot, 32'd0);

        apply_stimulus(0, 1, 5'd30, 32'h1, 1, 5'd31, 32'h40, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'd30, 5'd31, 5'd30, 5'd31);
        check_output("dual_A_top", dataA_top, 32'h1);
        check_output("dual_B_top", dataB_top, 32'h40);
        check_output("dual_A_bot", dataA_bot, 32'h1);
        check_output("dual_B_bot", dataB_bot, 32'h40);

        apply_stimulus(0, 1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 1, 5'd3, 32'h66, 0, 0, 0, 5'd3, 0, 0, 0);
        check_output("reset_no_bypass", dataA_top, 32'h55);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd30, 0, 0);
        check_output("reset_cleared_r3", dataA_top, 32'd0);
        check_output("reset_cleared_r30", dataB_top, 32'd0);

        // Random traffic with a narrowed address range so conflicts and bypasses occur.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] at, ab;
            at = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ab = ($urandom_range(0, 1) == 0) ? at : 5'($urandom_range(0, 7));
            apply_stimulus(($urandom_range(0, 31) == 0),
                           1'($urandom), at, $urandom,
                           1'($urandom), ab, $urandom,
                           5'($urandom_range(0, 7)), at, ab, 5'($urandom));
            check_all_ports("rand");
            tick();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
